rbs_64_bit_seq: RTL and testbench

Sequential 64-bit ripple-borrow subtractor; the inverse arithmetic direction of the team's 64-bit ripple-carry adder. Computes d = a - b - b_in one CHUNK-wide slice per clock, rippling the borrow through a registered borrow flop between slices. Used wherever the datapath needs a subtract with a start/done handshake and a low per-cycle gate count. Results are held stable until the next accepted start.

---
 rtl/rbs_64_bit_seq.sv | 134 +++++++++++++
 tb/tb_rbs_64_bit_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rbs_64_bit_seq.sv
// Sequential ripple-borrow subtractor: d = a - b - b_in, one CHUNK-wide slice per
// clock, with the borrow carried between slices in a flop. start/done handshake.
module rbs_64_bit_seq #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             b_out,
   output logic             ovf
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, b_q, d_q;
   logic               borrow_q, b_out_q, ovf_q;
   logic [IDX_W-1:0]   idx_q;

   logic               accept;
   logic               last_slice;
   logic [CHUNK-1:0]   a_slice, b_slice, diff;
   logic               borrow_nxt;

   // Both IDLE and the single DONE cycle accept a new request.
   assign accept     = start && (state_q != RUN);
   assign last_slice = (idx_q == IDX_W'(N - 1));

   always_comb begin
      // NOTE: every variable gets a default before the loop so no latch is inferred.
      a_slice = '0;
      b_slice = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_slice = a_q[i*CHUNK +: CHUNK];
            b_slice = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   // One extra bit on the left catches the borrow out of the slice.
   assign {borrow_nxt, diff} = {1'b0, a_slice} - {1'b0, b_slice} - {{CHUNK{1'b0}}, borrow_q};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_slice) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state_q)
         IDLE: ready = 1'b1;
         RUN:  busy  = 1'b1;
         DONE: begin
            ready = 1'b1;
            done  = 1'b1;
         end
         default: ready = 1'b0;
      endcase
   end

   // Operand, borrow and result datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         d_q      <= '0;
         borrow_q <= 1'b0;
         b_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
         idx_q    <= '0;
      end else if (accept) begin
         a_q      <= a;
         b_q      <= b;
         d_q      <= '0;
         borrow_q <= b_in;
         b_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
         idx_q    <= '0;
      end else if (state_q == RUN) begin
         for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) d_q[i*CHUNK +: CHUNK] <= diff;
         end
         borrow_q <= borrow_nxt;
         if (last_slice) begin
            idx_q   <= '0;
            b_out_q <= borrow_nxt;
            // The last slice holds the result MSB, so diff supplies d's sign bit.
            ovf_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[CHUNK-1] != a_q[WIDTH-1]);
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign d     = d_q;
   assign b_out = b_out_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_rbs_64_bit_seq.sv
// Directed bench for rbs_64_bit_seq: table of operand/result vectors plus
// hand-written sequences for ignored starts, back-to-back starts and mid-run reset.
module tb_rbs_64_bit_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] a_i = '0;
   logic [63:0] b_i = '0;
   logic        b_in_i = 1'b0;
   logic        ready, busy, done;
   logic [63:0] d;
   logic        b_out, ovf;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        bin;
      logic [63:0] exp_d;
      logic        exp_bout;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[9];

   rbs_64_bit_seq #(.WIDTH(64), .CHUNK(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a_i),
      .b     (b_i),
      .b_in  (b_in_i),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .b_out (b_out),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Accepts one operation starting #1 after an edge with ready=1, scrambles the
   // inputs after the accept edge, and counts edges until done (bounded).
   task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input logic bin,
                         input string tag, output int lat);
      a_i    = av;
      b_i    = bv;
      b_in_i = bin;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      a_i    = {$urandom, $urandom};
      b_i    = {$urandom, $urandom};
      b_in_i = ~bin;
      check({tag, " busy after accept"}, 64'(busy), 64'd1);
      check({tag, " d cleared on accept"}, d, 64'd0);
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic check_result(input string tag, input vec_t v, input int lat);
      check({tag, " latency"}, 64'(lat), 64'd4);
      check({tag, " d"}, d, v.exp_d);
      check({tag, " b_out"}, 64'(b_out), 64'(v.exp_bout));
      check({tag, " ovf"}, 64'(ovf), 64'(v.exp_ovf));
   endtask

   initial begin
      int lat;
      int seen_done;
      vecs[0] = '{64'd98765432198765, 64'd84935734758545, 1'b1, 64'd13829697440219, 1'b0, 1'b0};
      vecs[1] = '{64'd5, 64'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
      vecs[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
      vecs[3] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
      vecs[4] = '{64'h0001_0000_0000_0000, 64'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[5] = '{64'd0, 64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
      vecs[6] = '{64'h123, 64'h123, 1'b0, 64'd0, 1'b0, 1'b0};
      vecs[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
      vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};

      // Reset state.
      #12;
      check("reset ready", 64'(ready), 64'd1);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset d", d, 64'd0);
      check("reset b_out", 64'(b_out), 64'd0);
      check("reset ovf", 64'(ovf), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table of single operations, each followed by the DONE->IDLE hold check.
      for (int i = 0; i < 9; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         run_op(vecs[i].a, vecs[i].b, vecs[i].bin, tag, lat);
         check_result(tag, vecs[i], lat);
         @(posedge clk);
         #1;
         check({tag, " done one cycle"}, 64'(done), 64'd0);
         check({tag, " d held"}, d, vecs[i].exp_d);
         check({tag, " ready idle"}, 64'(ready), 64'd1);
      end

      // start pulsed during RUN with other operands must be ignored.
      a_i    = vecs[0].a;
      b_i    = vecs[0].b;
      b_in_i = vecs[0].bin;
      start  = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         start  = 1'b1;
         a_i    = {$urandom, $urandom};
         b_i    = {$urandom, $urandom};
         b_in_i = k[0];
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      check("ignored start still busy", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      check("ignored start done", 64'(done), 64'd1);
      check("ignored start d", d, vecs[0].exp_d);
      check("ignored start b_out", 64'(b_out), 64'(vecs[0].exp_bout));

      // Back-to-back: start accepted in the DONE cycle.
      a_i    = vecs[2].a;
      b_i    = vecs[2].b;
      b_in_i = vecs[2].bin;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b done dropped", 64'(done), 64'd0);
      check("b2b busy", 64'(busy), 64'd1);
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_result("b2b", vecs[2], lat);
      @(posedge clk);
      #1;

      // Reset asserted after edge 2 of a RUN aborts immediately.
      a_i    = vecs[0].a;
      b_i    = vecs[0].b;
      b_in_i = vecs[0].bin;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("pre-abort partial d", 64'(d != 64'd0), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort ready", 64'(ready), 64'd1);
      check("abort done", 64'(done), 64'd0);
      check("abort d", d, 64'd0);
      check("abort b_out", 64'(b_out), 64'd0);
      check("abort ovf", 64'(ovf), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done) seen_done++;
      end
      check("no done after abort", 64'(seen_done), 64'd0);
      run_op(vecs[4].a, vecs[4].b, vecs[4].bin, "post-reset", lat);
      check_result("post-reset", vecs[4], lat);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
